// File: rtl/mem_arbiter_if.sv
// Request/RAM bundle between the fetch/data requesters, the arbiter and the RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [1:0]        ramstate;
    logic [DATA_W-1:0] ramload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic              iwait;
    logic              dwait;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data requests beat instruction fetches, RAM ERRORs are retried.
// Build macro ARB_PERF_EN adds saturating grant/error counters.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
`ifdef ARB_PERF_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.slave  bus
`ifdef ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] dgrant_cnt,
    output logic [CNT_W-1:0] igrant_cnt,
    output logic [CNT_W-1:0] err_cnt
`endif
);
    localparam logic [1:0] RAM_ACCESS = 2'b10;
    localparam logic [1:0] RAM_ERROR  = 2'b11;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT, RETRY} state_t;

    state_t state;
    logic   retry_owner;
    logic   dreq;
    logic   access;
    logic   error;

    logic              ramren_c;
    logic              ramwen_c;
    logic [ADDR_W-1:0] ramaddr_c;
    logic [DATA_W-1:0] ramstore_c;
    logic              iwait_c;
    logic              dwait_c;
    logic [DATA_W-1:0] iload_c;
    logic [DATA_W-1:0] dload_c;

    assign dreq   = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RAM_ACCESS);
    assign error  = (bus.ramstate == RAM_ERROR);

    // Arbitration state; every completion or withdrawal returns through IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            retry_owner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq)          state <= DGRANT;
                    else if (bus.iREN) state <= IGRANT;
                end
                DGRANT: begin
                    if (!dreq || access) begin
                        state <= IDLE;
                    end else if (error) begin
                        state       <= RETRY;
                        retry_owner <= 1'b1;
                    end
                end
                IGRANT: begin
                    if (!bus.iREN || access) begin
                        state <= IDLE;
                    end else if (error) begin
                        state       <= RETRY;
                        retry_owner <= 1'b0;
                    end
                end
                RETRY: begin
                    if (retry_owner) state <= dreq ? DGRANT : IDLE;
                    else             state <= bus.iREN ? IGRANT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port and requester responses, combinational from state and inputs.
    always_comb begin
        ramren_c   = 1'b0;
        ramwen_c   = 1'b0;
        ramaddr_c  = '0;
        ramstore_c = '0;
        iload_c    = '0;
        dload_c    = '0;
        iwait_c    = bus.iREN;
        dwait_c    = dreq;
        case (state)
            DGRANT: begin
                ramaddr_c  = bus.daddr;
                ramstore_c = bus.dstore;
                ramwen_c   = bus.dWEN;
                ramren_c   = bus.dREN & ~bus.dWEN;
                if (access) begin
                    dwait_c = 1'b0;
                    if (ramren_c) dload_c = bus.ramload;
                end
            end
            IGRANT: begin
                ramaddr_c = bus.iaddr;
                ramren_c  = bus.iREN;
                if (access) begin
                    iwait_c = 1'b0;
                    if (bus.iREN) iload_c = bus.ramload;
                end
            end
            default: ;
        endcase
    end

    assign bus.ramREN   = ramren_c;
    assign bus.ramWEN   = ramwen_c;
    assign bus.ramaddr  = ramaddr_c;
    assign bus.ramstore = ramstore_c;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    assign bus.iload    = iload_c;
    assign bus.dload    = dload_c;

`ifdef ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dgrant_cnt <= '0;
            igrant_cnt <= '0;
            err_cnt    <= '0;
        end else begin
            if (state == DGRANT && access && dgrant_cnt != CNT_MAX)
                dgrant_cnt <= dgrant_cnt + CNT_W'(1);
            if (state == IGRANT && access && igrant_cnt != CNT_MAX)
                igrant_cnt <= igrant_cnt + CNT_W'(1);
            if ((state == DGRANT || state == IGRANT) && error && err_cnt != CNT_MAX)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences, random run vs. a port-ownership model.
module tb_mem_arbiter;
    localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACC = 2'b10, ERR = 2'b11;
    localparam logic [31:0] IA = 32'h40, DA = 32'h100, DS = 32'h1234, LD = 32'hDEADBEEF;

    logic CLK;
    logic nRST;
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_EN
    logic [3:0] dgrant_cnt, igrant_cnt, err_cnt;
    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus),
        .dgrant_cnt(dgrant_cnt), .igrant_cnt(igrant_cnt), .err_cnt(err_cnt)
    );
`else
    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .bus(bus)
    );
`endif

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren, dren, dwen;
        logic [1:0]  rs;
        logic        ren, wen;
        logic [31:0] addr, store;
        logic        iw, dw;
        logic [31:0] il, dl;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic ir, dr, dw, input logic [1:0] rs,
                                input logic e_ren, e_wen, input logic [31:0] e_addr, e_store,
                                input logic e_iw, e_dw, input logic [31:0] e_il, e_dl);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs;
        v.ren = e_ren; v.wen = e_wen; v.addr = e_addr; v.store = e_store;
        v.iw = e_iw; v.dw = e_dw; v.il = e_il; v.dl = e_dl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    task automatic check_outs(input string tag, input logic e_ren, e_wen,
                              input logic [31:0] e_addr, e_store, input logic e_iw, e_dw,
                              input logic [31:0] e_il, e_dl);
        chk({tag, ".ramREN"},   32'(bus.ramREN),  32'(e_ren));
        chk({tag, ".ramWEN"},   32'(bus.ramWEN),  32'(e_wen));
        chk({tag, ".ramaddr"},  bus.ramaddr,      e_addr);
        chk({tag, ".ramstore"}, bus.ramstore,     e_store);
        chk({tag, ".iwait"},    32'(bus.iwait),   32'(e_iw));
        chk({tag, ".dwait"},    32'(bus.dwait),   32'(e_dw));
        chk({tag, ".iload"},    bus.iload,        e_il);
        chk({tag, ".dload"},    bus.dload,        e_dl);
    endtask

    // One cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input logic ir, dr, dw, input logic [1:0] rs);
        @(negedge CLK);
        bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw; bus.ramstate = rs;
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0;
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Reference model: who currently owns the RAM port, and whose retry gap is pending.
    localparam int H_NONE = 0, H_DATA = 1, H_INSTR = 2, H_GAP = 3;
    int holder, gap_for, m_dcnt, m_icnt, m_ecnt;

    task automatic model_check(input string tag);
        logic dreq;
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        dreq  = bus.dREN | bus.dWEN;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0;
        if (holder == H_DATA) begin
            e_addr = bus.daddr; e_store = bus.dstore;
            e_wen = bus.dWEN; e_ren = bus.dREN && !bus.dWEN;
            if (bus.ramstate == ACC && e_ren) e_dl = bus.ramload;
        end else if (holder == H_INSTR) begin
            e_addr = bus.iaddr; e_ren = bus.iREN;
            if (bus.ramstate == ACC && bus.iREN) e_il = bus.ramload;
        end
        e_iw = bus.iREN && !(holder == H_INSTR && bus.ramstate == ACC);
        e_dw = dreq && !(holder == H_DATA && bus.ramstate == ACC);
        check_outs(tag, e_ren, e_wen, e_addr, e_store, e_iw, e_dw, e_il, e_dl);
        // Ownership transfer for the next cycle
        case (holder)
            H_NONE:  holder = dreq ? H_DATA : (bus.iREN ? H_INSTR : H_NONE);
            H_DATA, H_INSTR: begin
                if (bus.ramstate == ACC) begin
                    if (holder == H_DATA) m_dcnt++; else m_icnt++;
                end
                if (bus.ramstate == ERR) m_ecnt++;
                if (!(holder == H_DATA ? dreq : bus.iREN) || bus.ramstate == ACC) holder = H_NONE;
                else if (bus.ramstate == ERR) begin gap_for = holder; holder = H_GAP; end
            end
            default: holder = (gap_for == H_DATA) ? (dreq ? H_DATA : H_NONE)
                                                  : (bus.iREN ? H_INSTR : H_NONE);
        endcase
    endtask

    function automatic logic [31:0] sat15(input int n);
        return (n > 15) ? 32'd15 : 32'(n);
    endfunction

    initial begin
        nRST = 1'b0;
        bus.iREN = 1'b1; bus.dREN = 1'b0; bus.dWEN = 1'b1;
        bus.iaddr = IA; bus.daddr = DA; bus.dstore = DS;
        bus.ramstate = FREE; bus.ramload = LD;

        // Reset state: no enables, waits follow requests
        @(negedge CLK); #1;
        check_outs("reset", 0, 0, 0, 0, 1, 1, 0, 0);
        bus.iREN = 1'b0; bus.dWEN = 1'b0;
        #1;
        check_outs("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ARB_PERF_EN
        chk("reset.dgrant_cnt", 32'(dgrant_cnt), 0);
        chk("reset.err_cnt", 32'(err_cnt), 0);
`endif
        @(negedge CLK);
        nRST = 1'b1;

        // Directed table: fetch, D-write vs fetch collision, no preemption of IGRANT
        vecs[0]  = mk(0,0,0,FREE, 0,0,0,0,   0,0,0,0);
        vecs[1]  = mk(1,0,0,FREE, 0,0,0,0,   1,0,0,0);
        vecs[2]  = mk(1,0,0,BUSY, 1,0,IA,0,  1,0,0,0);
        vecs[3]  = mk(1,0,0,ACC,  1,0,IA,0,  0,0,LD,0);
        vecs[4]  = mk(0,0,0,FREE, 0,0,0,0,   0,0,0,0);
        vecs[5]  = mk(1,0,1,FREE, 0,0,0,0,   1,1,0,0);
        vecs[6]  = mk(1,0,1,BUSY, 0,1,DA,DS, 1,1,0,0);
        vecs[7]  = mk(1,0,1,ACC,  0,1,DA,DS, 1,0,0,0);
        vecs[8]  = mk(1,0,0,FREE, 0,0,0,0,   1,0,0,0);
        vecs[9]  = mk(1,0,0,ACC,  1,0,IA,0,  0,0,LD,0);
        vecs[10] = mk(0,0,0,FREE, 0,0,0,0,   0,0,0,0);
        vecs[11] = mk(1,0,0,FREE, 0,0,0,0,   1,0,0,0);
        vecs[12] = mk(1,1,0,BUSY, 1,0,IA,0,  1,1,0,0);
        vecs[13] = mk(1,1,0,ACC,  1,0,IA,0,  0,1,LD,0);
        vecs[14] = mk(1,1,0,FREE, 0,0,0,0,   1,1,0,0);
        vecs[15] = mk(1,1,0,ACC,  1,0,DA,DS, 1,0,0,LD);
        vecs[16] = mk(0,0,0,FREE, 0,0,0,0,   0,0,0,0);
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].iren, vecs[i].dren, vecs[i].dwen, vecs[i].rs);
            check_outs($sformatf("v%0d", i), vecs[i].ren, vecs[i].wen, vecs[i].addr,
                       vecs[i].store, vecs[i].iw, vecs[i].dw, vecs[i].il, vecs[i].dl);
        end
`ifdef ARB_PERF_EN
        chk("table.dgrant_cnt", 32'(dgrant_cnt), 2);
        chk("table.igrant_cnt", 32'(igrant_cnt), 3);
        chk("table.err_cnt", 32'(err_cnt), 0);
`endif

        // Data read hits ERROR once: one RETRY gap, then reissue to the same address
        do_reset();
        bus.daddr = 32'h200; bus.ramload = 32'hCAFEF00D;
        step(0,1,0,FREE); check_outs("err.idle",  0,0,0,0,          0,1,0,0);
        step(0,1,0,ERR);  check_outs("err.grant", 1,0,32'h200,DS,   0,1,0,0);
        step(0,1,0,FREE); check_outs("err.retry", 0,0,0,0,          0,1,0,0);
        step(0,1,0,ACC);  check_outs("err.again", 1,0,32'h200,DS,   0,0,0,32'hCAFEF00D);
        step(0,0,0,FREE); check_outs("err.done",  0,0,0,0,          0,0,0,0);
`ifdef ARB_PERF_EN
        chk("err.err_cnt", 32'(err_cnt), 1);
        chk("err.dgrant_cnt", 32'(dgrant_cnt), 1);
`endif

        // Async reset during a BUSY data grant, then re-arbitration and a withdrawn request
        do_reset();
        step(0,1,0,FREE); check_outs("rst.idle", 0,0,0,0, 0,1,0,0);
        step(0,1,0,BUSY); check_outs("rst.busy", 1,0,32'h200,DS, 0,1,0,0);
        #1 nRST = 1'b0;
        #1;
        check_outs("rst.async", 0,0,0,0, 0,1,0,0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        check_outs("rst.rearb", 0,0,0,0, 0,1,0,0);
        step(0,1,0,BUSY); check_outs("rst.regrant", 1,0,32'h200,DS, 0,1,0,0);
        step(0,0,0,BUSY); check_outs("drop.same",   0,0,32'h200,DS, 0,0,0,0);
        step(1,0,0,FREE); check_outs("drop.idle",   0,0,0,0, 1,0,0,0);
        step(1,0,0,BUSY); check_outs("drop.ifetch", 1,0,32'h40,0, 1,0,0,0);
        step(0,0,0,FREE);
`ifdef ARB_PERF_EN
        chk("drop.dgrant_cnt", 32'(dgrant_cnt), 0);
`endif

`ifdef ARB_PERF_EN
        // 17 instruction accesses saturate a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1,0,0,FREE);
            step(1,0,0,ACC);
        end
        step(0,0,0,FREE);
        chk("sat.igrant_cnt", 32'(igrant_cnt), 32'hF);
        chk("sat.dgrant_cnt", 32'(dgrant_cnt), 0);
`endif

        // Random traffic against the ownership model
        do_reset();
        holder = H_NONE; gap_for = H_NONE; m_dcnt = 0; m_icnt = 0; m_ecnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            bus.iREN     = ($urandom_range(0, 3) != 0);
            bus.dREN     = ($urandom_range(0, 3) == 0);
            bus.dWEN     = ($urandom_range(0, 5) == 0);
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            bus.ramstate = 2'($urandom_range(0, 3));
            #1;
            model_check($sformatf("rnd%0d", c));
        end
`ifdef ARB_PERF_EN
        @(negedge CLK);
        bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.ramstate = FREE;
        #1;
        chk("rnd.dgrant_cnt", 32'(dgrant_cnt), sat15(m_dcnt));
        chk("rnd.igrant_cnt", 32'(igrant_cnt), sat15(m_icnt));
        chk("rnd.err_cnt", 32'(err_cnt), sat15(m_ecnt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
